// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M/RV64M multiply/divide encodings and unit states
package riscv_pkg;
  localparam int MDU_NB_OP = 8;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_t;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_div.sv
// mdu_div: iterative unsigned restoring divider, one quotient bit per cycle
module mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN);
  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN:0]   trial, diff;
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(XLEN - 1);
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_d = cnt_q - CW'(1);
      run_d = cnt_q != '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  // high during the cycle that computes the last quotient bit
  assign done      = run_q & (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/exe_mdu.sv
// exe_mdu: RV32M/RV64M multiply/divide unit with valid/ready request and result handshakes
module exe_mdu
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_v_i,
  output logic            req_rdy_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_adr_i,
  input  logic            flush_i,
  output logic            res_v_o,
  input  logic            res_rdy_i,
  output logic [XLEN-1:0] res_data_o,
  output logic [4:0]      res_adr_o,
  output logic            busy_o
);
  localparam int CW = 3;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_t        state_q, state_d;
  logic [2:0]        op_q, op_d, m_op;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
  logic [4:0]        rd_q, rd_d, res_adr_q, res_adr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   m_a, m_b, mul_res;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic              acc, sgn_i, neg_a, neg_b, div_zero, div_ovf, div_start, div_done;
  logic              sgn_q, q_neg, r_neg;
  logic [XLEN-1:0]   a_mag, b_mag, quick_res, quo, rem, fix_res;
  assign req_rdy_o  = (state_q == IDLE) & ~flush_i;
  assign acc        = req_v_i & req_rdy_o;
  assign res_v_o    = state_q == DONE;
  assign busy_o     = state_q != IDLE;
  assign res_data_o = res_q;
  assign res_adr_o  = res_adr_q;
  // with MUL_LAT = 1 the product is taken straight from the request operands
  always_comb begin
    m_op    = state_q == IDLE ? op_i : op_q;
    m_a     = state_q == IDLE ? rs1_i : rs1_q;
    m_b     = state_q == IDLE ? rs2_i : rs2_q;
    ext_a   = {{XLEN{(m_op == MD_MULH || m_op == MD_MULHSU) & m_a[XLEN-1]}}, m_a};
    ext_b   = {{XLEN{(m_op == MD_MULH) & m_b[XLEN-1]}}, m_b};
    prod    = ext_a * ext_b;
    mul_res = m_op == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
  always_comb begin
    sgn_i     = ~op_i[0];
    neg_a     = sgn_i & rs1_i[XLEN-1];
    neg_b     = sgn_i & rs2_i[XLEN-1];
    a_mag     = neg_a ? -rs1_i : rs1_i;
    b_mag     = neg_b ? -rs2_i : rs2_i;
    div_zero  = ~|rs2_i;
    div_ovf   = sgn_i & (rs1_i == MIN_NEG) & (&rs2_i);
    quick_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
    sgn_q     = ~op_q[0];
    q_neg     = sgn_q & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    r_neg     = sgn_q & rs1_q[XLEN-1];
    fix_res   = op_q[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
  end
  mdu_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_adr_d = res_adr_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        op_d  = op_i;
        rs1_d = rs1_i;
        rs2_d = rs2_i;
        rd_d  = rd_adr_i;
        if (!op_i[2]) begin
          if (MUL_LAT == 1) begin
            state_d   = DONE;
            res_d     = mul_res;
            res_adr_d = rd_adr_i;
          end else begin
            state_d = MUL;
            cnt_d   = CW'(MUL_LAT - 1);
          end
        end else if (div_zero || div_ovf) begin
          state_d   = DONE;
          res_d     = quick_res;
          res_adr_d = rd_adr_i;
        end else begin
          state_d   = DIV;
          div_start = 1'b1;
        end
      end
      MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          res_d     = mul_res;
          res_adr_d = rd_q;
        end
      end
      DIV:  state_d = div_done ? FIX : DIV;
      FIX: begin
        state_d   = DONE;
        res_d     = fix_res;
        res_adr_d = rd_q;
      end
      DONE: state_d = res_rdy_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // a flush never lets a half-finished result reach the outputs
    if (flush_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      res_d     = res_q;
      res_adr_d = res_adr_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_adr_q <= res_adr_d;
    end
endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: directed and randomized checks of exe_mdu against an arithmetic reference model
module tb_exe_mdu;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_v = 1'b0, req_rdy_o;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_adr = '0;
  logic        flush = 1'b0;
  logic        res_v_o, res_rdy = 1'b0;
  logic [31:0] res_data_o;
  logic [4:0]  res_adr_o;
  logic        busy_o;
  int          n_chk = 0, n_err = 0;
  typedef struct {logic [2:0] op; logic [31:0] a, b, e; int lat;} vec_t;
  vec_t dir[$];

  exe_mdu #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_v_i(req_v), .req_rdy_o(req_rdy_o),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_adr_i(rd_adr), .flush_i(flush),
    .res_v_o(res_v_o), .res_rdy_i(res_rdy), .res_data_o(res_data_o),
    .res_adr_o(res_adr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    logic [63:0] u;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 2;
    if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] adr);
    req_v  = 1'b1;
    op     = o;
    rs1    = a;
    rs2    = b;
    rd_adr = adr;
    @(posedge clk);
    #1 req_v = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] adr, input logic [31:0] exp_d, input int exp_lat, input int hold);
    int lat;
    check("req_rdy_before", req_rdy_o, 1);
    issue(o, a, b, adr);
    lat = 1;
    while (!res_v_o && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, exp_lat);
    check("res_data", res_data_o, exp_d);
    check("res_adr", res_adr_o, adr);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_v", res_v_o, 1);
      check("hold_data", res_data_o, exp_d);
      check("hold_adr", res_adr_o, adr);
      check("hold_req_rdy", req_rdy_o, 0);
    end
    res_rdy = 1'b1;
    @(posedge clk);
    #1 res_rdy = 1'b0;
    check("idle_busy", busy_o, 0);
    check("idle_req_rdy", req_rdy_o, 1);
  endtask

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    logic [4:0] adr;
    bit seen;
    dir.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
    dir.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
    dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
    dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2});
    dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
    dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
    dir.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 34});
    dir.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34});
    dir.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    dir.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 1});
    dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_v", res_v_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", res_data_o, 0);
    check("rst_adr", res_adr_o, 0);
    check("rst_req_rdy", req_rdy_o, 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (dir[i]) run_op(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), dir[i].e, dir[i].lat, 0);
    for (int i = 0; i < 150; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = pick();
      b   = pick();
      adr = 5'($urandom);
      run_op(o, a, b, adr, ref_res(o, a, b), ref_lat(o, a, b), $urandom_range(0, 3));
    end
    run_op(3'd5, 32'd1000, 32'd9, 5'd17, 32'd111, 34, 5);
    // flush in cycle 10 of a divide
    issue(3'd4, 32'd1000, 32'd3, 5'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("div_busy_c10", busy_o, 1);
    flush = 1'b1;
    #1 check("flush_req_rdy", req_rdy_o, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy_c11", busy_o, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= res_v_o;
    end
    check("flush_no_result", seen, 0);
    flush = 1'b1;
    req_v = 1'b1;
    op    = 3'd0;
    rs1   = 32'd3;
    rs2   = 32'd4;
    #1 check("flush_req_blocked", req_rdy_o, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_v = 1'b0;
    check("flush_req_busy", busy_o, 0);
    @(posedge clk);
    #1 check("flush_req_no_res", res_v_o, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 2, 0);
    // asynchronous reset in the middle of a divide
    issue(3'd6, 32'd12345, 32'd67, 5'd30);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_res_v", res_v_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_data", res_data_o, 0);
    check("arst_adr", res_adr_o, 0);
    check("arst_req_rdy", req_rdy_o, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE, 34, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exe_mdu.md
# exe_mdu

Parametrised multiply/divide unit for the RV32M/RV64M extension. It sits beside the execute stage's single-cycle ALU, shifter, branch unit and load/store unit, and accepts one instruction at a time over a valid/ready handshake. Multiplies complete after a configurable latency; divides and remainders run iteratively, one quotient bit per cycle. The result is held until the write-back side accepts it, and a flush cancels any operation in flight.

## Interface
- XLEN, default 32: operand and result width; legal values are 32 and 64.
- MUL_LAT, default 2: cycles from acceptance to result-valid for MUL*; legal range 1..4.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_v_i  in  1  request valid.
- req_rdy_o  out  1  unit can accept a request.
- op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  XLEN  dividend / multiplicand.
- rs2_i  in  XLEN  divisor / multiplier.
- rd_adr_i  in  5  destination register, carried through with the request.
- flush_i  in  1  cancel the in-flight operation (branch or exception in the execute stage).
- res_v_o  out  1  result valid.
- res_rdy_i  in  1  write-back accepts the result.
- res_data_o  out  XLEN  result.
- res_adr_o  out  5  destination register of the result.
- busy_o  out  1  state is not IDLE; the decode stage uses it for hazard stall.

## Operation
- State machine states: IDLE, MUL, DIV, FIX, DONE.
- Reset values: state IDLE, res_v_o 0, res_data_o 0, res_adr_o 0, busy_o 0, all counters 0. req_rdy_o is 1 after reset.
- req_rdy_o = (state == IDLE) & ~flush_i.
- Acceptance: req_v_i & req_rdy_o. On acceptance, op_i, rs1_i, rs2_i and rd_adr_i are registered.
- MUL path, ops 0..3:
  - Operands are extended to XLEN+1 bits: signed for rs1 in MULH and MULHSU, signed for rs2 in MULH only.
  - The 2*XLEN+2-bit product is formed.
  - MUL returns the low XLEN bits; the other ops return bits [2*XLEN-1:XLEN].
  - State goes IDLE -> MUL; a counter loaded with MUL_LAT-1 decrements; at 0 the result is latched and state goes to DONE. When MUL_LAT = 1, state goes IDLE -> DONE directly.
- DIV path, ops 4..7:
  - Divide by zero (rs2 = 0) goes IDLE -> DONE with quotient all-ones and remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = most-negative value and rs2 = -1) goes IDLE -> DONE with quotient = rs1 and remainder = 0.
  - Otherwise: magnitudes are taken (signed ops only), state goes to DIV, and a restoring divider runs XLEN iterations with a counter from XLEN-1 down to 0.
  - Then FIX: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign. State goes to DONE.
- DONE:
  - res_v_o = 1; res_data_o and res_adr_o are stable.
  - On res_v_o & res_rdy_i, state goes to IDLE.
  - No new request is accepted in the same cycle.
- flush_i, in any state: next state is IDLE and res_v_o drops the next cycle. A result presented in the same cycle as flush_i is treated as not delivered, even if res_rdy_i = 1.
- Reset mid-operation returns all state to the reset values immediately.

## Timing
- Cycle 0 is the acceptance cycle.
- MUL*: res_v_o rises in cycle MUL_LAT.
- DIV*/REM* normal case: DIV occupies cycles 1..XLEN, FIX is cycle XLEN+1, and res_v_o rises in cycle XLEN+2 (34 for XLEN = 32).
- Divide-by-zero and overflow: res_v_o rises in cycle 1.
- Back-to-back issue: earliest next acceptance is the cycle after the result handshake. Throughput for MUL is therefore MUL_LAT+1 cycles per op.
- busy_o = (state != IDLE). It is registered and has no combinational path from req_v_i.
- res_data_o and res_adr_o change only on entry to DONE.

## Structure
- riscv_pkg gains:
  - md_op_t: enum of the 8 funct3 codes.
  - mdu_state_t: enum IDLE, MUL, DIV, FIX, DONE.
  - Constant MDU_NB_OP = 8.
- Sub-module mdu_div: iterative unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Parametrised by XLEN.
- Sign handling, the FSM and the multiplier stay in exe_mdu.

## Test plan
- MUL with rs1 = 7, rs2 = -3 (0xFFFFFFFD), MUL_LAT = 2 -> res_v_o in cycle 2, res_data_o = 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1 x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD in cycle 34. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF in cycle 1. REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000. REM of the same operands -> 0.
- Hold res_rdy_i = 0 for 5 cycles after DONE -> res_v_o, res_data_o and res_adr_o stay stable; req_rdy_o = 0 throughout. Then res_rdy_i = 1 -> IDLE next cycle and req_rdy_o = 1.
- flush_i in cycle 10 of a DIV -> IDLE in cycle 11 and res_v_o never rises. flush_i together with req_v_i in IDLE -> not accepted. Assert reset_n low mid-DIV -> all outputs at reset values immediately.
